// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the Common Data Bus arbiter.
// Slot and broadcast payloads are sized by the CDB_* defaults below.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_FU       = 5;
  localparam int unsigned CDB_NUM_ROB      = 8;
  localparam int unsigned CDB_NUM_PR       = 64;
  localparam int unsigned CDB_DATA_W       = 64;
  localparam int unsigned CDB_STARVE_LIMIT = 4;
  localparam int unsigned CDB_ROB_W        = $clog2(CDB_NUM_ROB);
  localparam int unsigned CDB_PR_W         = $clog2(CDB_NUM_PR);
  localparam int unsigned CDB_CNT_W        = $clog2(CDB_STARVE_LIMIT + 1);

  typedef struct packed {
    logic                  valid;
    logic [CDB_PR_W-1:0]   T_idx;
    logic [CDB_ROB_W-1:0]  ROB_idx;
    logic [CDB_DATA_W-1:0] result;
    logic [CDB_CNT_W-1:0]  wait_cnt;
  } CDB_SLOT_t;

  // Broadcast payload seen by RS wakeup, Map Table and ROB.
  typedef struct packed {
    logic                  valid;
    logic [CDB_PR_W-1:0]   T_idx;
    logic [CDB_ROB_W-1:0]  ROB_idx;
    logic [CDB_DATA_W-1:0] result;
  } CDB_OUT_t;

  // Distance of a ROB index from a reference, modulo the ROB size.
  function automatic logic [CDB_ROB_W-1:0] rob_dist(input logic [CDB_ROB_W-1:0] idx,
                                                     input logic [CDB_ROB_W-1:0] ref_idx);
    return idx - ref_idx;
  endfunction

endpackage

// File: rtl/cdb_age_select.sv
// Picks one holding slot: starved slots first (lowest index), else the oldest by
// ROB age, ties to the lowest index. Purely combinational, one-hot grant.
module cdb_age_select
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU = CDB_NUM_FU,
  parameter int unsigned ROB_W  = CDB_ROB_W
) (
  input  logic [NUM_FU-1:0]            valid_i,
  input  logic [NUM_FU-1:0]            starve_i,
  input  logic [NUM_FU-1:0][ROB_W-1:0] age_i,
  output logic [NUM_FU-1:0]            grant_o
);

  localparam int unsigned KEY_W = ROB_W + 1;
  localparam int unsigned IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] best_key;
  logic [IDX_W-1:0] best_idx;
  logic             found;

  // Starved slots map to key 0; strict less-than keeps the lowest index on ties.
  always_comb begin
    grant_o  = '0;
    key      = '0;
    best_key = '1;
    best_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      key = starve_i[i] ? KEY_W'(0) : {1'b1, age_i[i]};
      if (valid_i[i] && (!found || (key < best_key))) begin
        found    = 1'b1;
        best_key = key;
        best_idx = IDX_W'(i);
      end
    end
    if (found) begin
      grant_o[best_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per FU, one registered broadcast per
// cycle, oldest-first with starvation override and rollback squash.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU       = CDB_NUM_FU,
  parameter int unsigned NUM_ROB      = CDB_NUM_ROB,
  parameter int unsigned NUM_PR       = CDB_NUM_PR,
  parameter int unsigned DATA_W       = CDB_DATA_W,
  parameter int unsigned STARVE_LIMIT = CDB_STARVE_LIMIT
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      en,
  input  logic                                      rollback_en,
  input  logic [$clog2(NUM_ROB)-1:0]                ROB_rollback_idx,
  input  logic [$clog2(NUM_ROB)-1:0]                diff_ROB,
  input  logic [$clog2(NUM_ROB)-1:0]                ROB_head_idx,
  input  logic [NUM_FU-1:0]                         fu_done,
  input  logic [NUM_FU-1:0][$clog2(NUM_PR)-1:0]     fu_T_idx,
  input  logic [NUM_FU-1:0][$clog2(NUM_ROB)-1:0]    fu_ROB_idx,
  input  logic [NUM_FU-1:0][DATA_W-1:0]             fu_result,
  output logic [NUM_FU-1:0]                         fu_stall,
  output logic                                      CDB_valid,
  output logic [$clog2(NUM_PR)-1:0]                 CDB_T_idx,
  output logic [$clog2(NUM_ROB)-1:0]                CDB_ROB_idx,
  output logic [DATA_W-1:0]                         CDB_result
);

  localparam int unsigned ROB_W = $clog2(NUM_ROB);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  CDB_SLOT_t [NUM_FU-1:0] slot_q, slot_d;
  CDB_OUT_t               cdb_q, cdb_d;

  logic [NUM_FU-1:0]            slot_valid;
  logic [NUM_FU-1:0]            starve;
  logic [NUM_FU-1:0]            cand;
  logic [NUM_FU-1:0]            grant;
  logic [NUM_FU-1:0]            squash_slot;
  logic [NUM_FU-1:0]            squash_in;
  logic [NUM_FU-1:0]            slot_busy;
  logic [NUM_FU-1:0][ROB_W-1:0] age;

  // Per-slot age, starvation and rollback classification.
  always_comb begin
    slot_valid  = '0;
    starve      = '0;
    cand        = '0;
    squash_slot = '0;
    squash_in   = '0;
    age         = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      slot_valid[i]  = slot_q[i].valid;
      age[i]         = rob_dist(slot_q[i].ROB_idx, ROB_head_idx);
      starve[i]      = (slot_q[i].wait_cnt == CNT_W'(STARVE_LIMIT));
      squash_slot[i] = rollback_en && slot_q[i].valid &&
                       (rob_dist(slot_q[i].ROB_idx, ROB_rollback_idx) <= diff_ROB);
      squash_in[i]   = rollback_en && fu_done[i] &&
                       (rob_dist(fu_ROB_idx[i], ROB_rollback_idx) <= diff_ROB);
      cand[i]        = en && slot_q[i].valid && !squash_slot[i];
    end
  end

  cdb_age_select #(
    .NUM_FU (NUM_FU),
    .ROB_W  (ROB_W)
  ) u_age_select (
    .valid_i  (cand),
    .starve_i (starve),
    .age_i    (age),
    .grant_o  (grant)
  );

  // A slot still occupied after this edge blocks its FU.
  assign slot_busy = slot_valid & ~squash_slot & ~grant;
  assign fu_stall  = en ? (slot_busy & ~squash_in) : slot_valid;

  // Slot update, counters and broadcast selection.
  always_comb begin
    slot_d = slot_q;
    cdb_d  = '0;
    if (en) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i]) begin
          cdb_d = '{valid:   1'b1,
                    T_idx:   slot_q[i].T_idx,
                    ROB_idx: slot_q[i].ROB_idx,
                    result:  slot_q[i].result};
        end
        if (grant[i] || squash_slot[i]) begin
          slot_d[i] = '0;
        end else if (slot_q[i].valid && !starve[i]) begin
          slot_d[i].wait_cnt = slot_q[i].wait_cnt + CNT_W'(1);
        end
        if (fu_done[i] && !squash_in[i] && !slot_busy[i]) begin
          slot_d[i] = '{valid:    1'b1,
                        T_idx:    fu_T_idx[i],
                        ROB_idx:  fu_ROB_idx[i],
                        result:   fu_result[i],
                        wait_cnt: '0};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
      cdb_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cdb_q  <= cdb_d;
    end
  end

  assign CDB_valid   = cdb_q.valid;
  assign CDB_T_idx   = cdb_q.T_idx;
  assign CDB_ROB_idx = cdb_q.ROB_idx;
  assign CDB_result  = cdb_q.result;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: stimulus queues expected broadcasts,
// a negedge monitor pops and compares them along with stall/reset expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NFU = 5;
  localparam int unsigned RW  = 3;
  localparam int unsigned PW  = 6;
  localparam int unsigned DW  = 64;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     en;
  logic                     rollback_en;
  logic [RW-1:0]            ROB_rollback_idx;
  logic [RW-1:0]            diff_ROB;
  logic [RW-1:0]            ROB_head_idx;
  logic [NFU-1:0]           fu_done;
  logic [NFU-1:0][PW-1:0]   fu_T_idx;
  logic [NFU-1:0][RW-1:0]   fu_ROB_idx;
  logic [NFU-1:0][DW-1:0]   fu_result;
  logic [NFU-1:0]           fu_stall;
  logic                     CDB_valid;
  logic [PW-1:0]            CDB_T_idx;
  logic [RW-1:0]            CDB_ROB_idx;
  logic [DW-1:0]            CDB_result;

  cdb_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .en               (en),
    .rollback_en      (rollback_en),
    .ROB_rollback_idx (ROB_rollback_idx),
    .diff_ROB         (diff_ROB),
    .ROB_head_idx     (ROB_head_idx),
    .fu_done          (fu_done),
    .fu_T_idx         (fu_T_idx),
    .fu_ROB_idx       (fu_ROB_idx),
    .fu_result        (fu_result),
    .fu_stall         (fu_stall),
    .CDB_valid        (CDB_valid),
    .CDB_T_idx        (CDB_T_idx),
    .CDB_ROB_idx      (CDB_ROB_idx),
    .CDB_result       (CDB_result)
  );

  always #5 clock = ~clock;

  CDB_OUT_t       exp_q[$];
  logic [NFU-1:0] exp_stall;
  logic           stall_chk;
  logic           zero_chk;
  logic           empty_chk;
  int             checks;
  int             errors;

  initial begin
    checks = 0;
    errors = 0;
  end

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clock) begin
    CDB_OUT_t e;
    if (!reset && CDB_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got T=%0d ROB=%0d res=%h, expected no broadcast",
                 CDB_T_idx, CDB_ROB_idx, CDB_result);
      end else begin
        e = exp_q.pop_front();
        if (CDB_T_idx !== e.T_idx || CDB_ROB_idx !== e.ROB_idx || CDB_result !== e.result) begin
          errors++;
          $display("FAIL cdb_payload: got T=%0d ROB=%0d res=%h, expected T=%0d ROB=%0d res=%h",
                   CDB_T_idx, CDB_ROB_idx, CDB_result, e.T_idx, e.ROB_idx, e.result);
        end
      end
    end
    if (stall_chk) begin
      checks++;
      if (fu_stall !== exp_stall) begin
        errors++;
        $display("FAIL fu_stall at %0t: got %b, expected %b", $time, fu_stall, exp_stall);
      end
    end
    if (zero_chk) begin
      checks++;
      if ({CDB_valid, CDB_T_idx, CDB_ROB_idx, CDB_result, fu_stall} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b T=%0d ROB=%0d res=%h stall=%b, expected all 0",
                 CDB_valid, CDB_T_idx, CDB_ROB_idx, CDB_result, fu_stall);
      end
    end
    if (empty_chk) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL cdb_missing: %0d expected broadcasts never seen, expected 0", exp_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    stall_chk = 1'b0;
    zero_chk  = 1'b0;
    empty_chk = 1'b0;
  endtask

  task automatic drive(input int i, input logic [PW-1:0] t, input logic [RW-1:0] r,
                       input logic [DW-1:0] d);
    fu_done[i]    = 1'b1;
    fu_T_idx[i]   = t;
    fu_ROB_idx[i] = r;
    fu_result[i]  = d;
  endtask

  task automatic expect_cdb(input logic [PW-1:0] t, input logic [RW-1:0] r,
                            input logic [DW-1:0] d);
    exp_q.push_back(CDB_OUT_t'{valid: 1'b1, T_idx: t, ROB_idx: r, result: d});
  endtask

  task automatic expect_stall(input logic [NFU-1:0] s);
    exp_stall = s;
    stall_chk = 1'b1;
  endtask

  initial begin
    stall_chk        = 1'b0;
    zero_chk         = 1'b0;
    empty_chk        = 1'b0;
    exp_stall        = '0;
    reset            = 1'b1;
    en               = 1'b1;
    rollback_en      = 1'b0;
    ROB_rollback_idx = '0;
    diff_ROB         = '0;
    ROB_head_idx     = '0;
    fu_done          = '0;
    fu_T_idx         = '0;
    fu_ROB_idx       = '0;
    fu_result        = '0;
    tick();
    tick();
    reset    = 1'b0;
    zero_chk = 1'b1;
    tick();

    // Single done: FU2, ROB 3, T 17.
    ROB_head_idx = 3'd0;
    expect_cdb(6'd17, 3'd3, 64'h1111);
    drive(2, 6'd17, 3'd3, 64'h1111);
    tick();
    fu_done = '0;
    expect_stall(5'b00000);
    tick();
    tick();

    // Age order with wrap, head=6: ROB 1,7,6 in FU0,1,4 -> ages 3,1,0.
    ROB_head_idx = 3'd6;
    expect_cdb(6'd14, 3'd6, 64'hA4);
    expect_cdb(6'd11, 3'd7, 64'hA1);
    expect_cdb(6'd10, 3'd1, 64'hA0);
    drive(0, 6'd10, 3'd1, 64'hA0);
    drive(1, 6'd11, 3'd7, 64'hA1);
    drive(4, 6'd14, 3'd6, 64'hA4);
    tick();
    fu_done = '0;
    expect_stall(5'b00011);
    tick();
    expect_stall(5'b00001);
    tick();
    expect_stall(5'b00000);
    tick();
    tick();

    // Tie: equal age in FU1 and FU3, lower index first.
    ROB_head_idx = 3'd0;
    expect_cdb(6'd21, 3'd2, 64'hB1);
    expect_cdb(6'd23, 3'd2, 64'hB3);
    drive(1, 6'd21, 3'd2, 64'hB1);
    drive(3, 6'd23, 3'd2, 64'hB3);
    tick();
    fu_done = '0;
    expect_stall(5'b01000);
    tick();
    expect_stall(5'b00000);
    tick();
    tick();

    // Starvation: FU0 at age 5 loses to FU2 refills at age 0 four times.
    for (int k = 0; k < 4; k++) expect_cdb(PW'(40 + k), 3'd0, DW'(64'hC20 + k));
    expect_cdb(6'd30, 3'd5, 64'hC0);
    expect_cdb(6'd44, 3'd0, 64'hC24);
    drive(0, 6'd30, 3'd5, 64'hC0);
    for (int k = 0; k < 5; k++) begin
      drive(2, PW'(40 + k), 3'd0, DW'(64'hC20 + k));
      tick();
      fu_done[0] = 1'b0;
      expect_stall((k < 4) ? 5'b00001 : 5'b00100);
    end
    fu_done[2] = 1'b0;
    tick();
    expect_stall(5'b00000);
    tick();
    tick();

    // Rollback: idx 4, span 2 squashes ROB 4,5,6; head=4 makes ROB 4 the would-be winner.
    ROB_head_idx = 3'd4;
    expect_cdb(6'd53, 3'd2, 64'hE3);
    drive(0, 6'd50, 3'd4, 64'hE0);
    drive(1, 6'd51, 3'd5, 64'hE1);
    drive(2, 6'd52, 3'd6, 64'hE2);
    drive(3, 6'd53, 3'd2, 64'hE3);
    tick();
    fu_done          = '0;
    rollback_en      = 1'b1;
    ROB_rollback_idx = 3'd4;
    diff_ROB         = 3'd2;
    drive(4, 6'd54, 3'd5, 64'hE4);
    expect_stall(5'b00000);
    tick();
    rollback_en = 1'b0;
    fu_done     = '0;
    expect_stall(5'b00000);
    tick();
    tick();
    tick();

    // en low for 3 cycles with FU0/FU1 held.
    ROB_head_idx = 3'd0;
    expect_cdb(6'd60, 3'd1, 64'hD0);
    expect_cdb(6'd61, 3'd2, 64'hD1);
    drive(0, 6'd60, 3'd1, 64'hD0);
    drive(1, 6'd61, 3'd2, 64'hD1);
    tick();
    fu_done = '0;
    en      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_stall(5'b00011);
      tick();
    end
    en = 1'b1;
    expect_stall(5'b00010);
    tick();
    expect_stall(5'b00000);
    tick();
    tick();

    // Reset while a result is held: dropped, no broadcast afterwards.
    drive(3, 6'd0, 3'd3, 64'hF3);
    tick();
    fu_done = '0;
    reset   = 1'b1;
    tick();
    zero_chk = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    empty_chk = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
